// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg -- shared definitions for the integrate-and-fire neuron layer.
//
// Contents:
//   neuron_state_e  : per-neuron FSM state encoding (INTEGRATE / REFRACTORY)
//   sat_kind_e      : classification returned by the saturation helper
//   cnt_width()     : refractory counter width, clog2(REFRAC+1), never below 1
//   acc_width()     : width of the signed accumulator that cannot overflow
//   sat_class()     : decides whether an accumulated value must be clamped to
//                     the potential maximum, floored at zero, or passed through
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } neuron_state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_ZERO = 2'd2
    } sat_kind_e;

    // Width of the sign-extended value handed to sat_class(); accumulators are
    // always far narrower than this.
    localparam int SAT_PROBE_W = 64;

    // A REFRAC of 0 still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int refrac);
        if (refrac < 1) begin
            return 1;
        end
        return $clog2(refrac + 1);
    endfunction

    // Potential plus NUM_INPUTS weights plus a sign bit. The wider of the
    // potential and weight widths is used as the base so that an unusually
    // wide weight cannot overflow the sum either.
    function automatic int acc_width(input int pot_w, input int weight_w,
                                     input int num_inputs);
        int base;
        base = (pot_w > weight_w) ? pot_w : weight_w;
        return base + $clog2(num_inputs) + 1;
    endfunction

    // Potentials are signed POT_W-bit values that are never negative, so the
    // legal range is [0, 2^(POT_W-1)-1].
    function automatic sat_kind_e sat_class(input logic signed [SAT_PROBE_W-1:0] value,
                                            input int pot_w);
        logic signed [SAT_PROBE_W-1:0] max_v;
        max_v = (64'sd1 <<< (pot_w - 1)) - 64'sd1;
        if (value < 0) begin
            return SAT_ZERO;
        end
        if (value > max_v) begin
            return SAT_MAX;
        end
        return SAT_NONE;
    endfunction

endpackage : snn_pkg

// File: rtl/if_neuron.sv
// -----------------------------------------------------------------------------
// if_neuron -- one integrate-and-fire neuron.
//
// On every step strobe in INTEGRATE the weights of all active inputs are added
// to the membrane potential (signed, clamped to [0, 2^(POT_W-1)-1]). Reaching
// THRESHOLD emits a one-cycle spike, clears the potential and starts a
// refractory period of REFRAC steps during which inputs are ignored.
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-low reset
//   step         : time-step strobe
//   spike_in     : presynaptic spikes, NUM_INPUTS bits
//   weights      : NUM_INPUTS signed weights, input i at i*WEIGHT_W
//   neuron_rst   : forces REFRACTORY with a full counter, no spike
//   spike_out    : one-cycle spike pulse
//   refrac_busy  : high while in REFRACTORY
//   potential    : membrane potential, POT_W bits
// -----------------------------------------------------------------------------
module if_neuron
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WEIGHT_W   = 8,
    parameter int POT_W      = 16,
    parameter int THRESHOLD  = 100,
    parameter int REFRAC     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step,
    input  logic [NUM_INPUTS-1:0]          spike_in,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
    input  logic                           neuron_rst,
    output logic                           spike_out,
    output logic                           refrac_busy,
    output logic [POT_W-1:0]               potential
);

    localparam int                ACC_W    = acc_width(POT_W, WEIGHT_W, NUM_INPUTS);
    localparam int                CNT_W    = cnt_width(REFRAC);
    localparam logic [CNT_W-1:0]  REFRAC_C = CNT_W'(REFRAC);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [POT_W-1:0]  THRESH_C = POT_W'(THRESHOLD);
    localparam logic [POT_W-1:0]  POT_MAX  = {1'b0, {(POT_W-1){1'b1}}};

    neuron_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POT_W-1:0] pot_q, pot_d;
    logic             spike_q, spike_d;
    logic             busy_q, busy_d;

    // Gated, sign-extended synaptic contributions.
    logic signed [ACC_W-1:0]       term [NUM_INPUTS];
    logic signed [ACC_W-1:0]       acc_sum;
    logic signed [SAT_PROBE_W-1:0] sat_probe;
    logic [POT_W-1:0]              pot_upd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_term
            assign term[gi] = spike_in[gi]
                            ? ACC_W'($signed(weights[gi*WEIGHT_W +: WEIGHT_W]))
                            : {ACC_W{1'b0}};
        end
    endgenerate

    always_comb begin
        acc_sum = ACC_W'($signed(pot_q));
        for (int i = 0; i < NUM_INPUTS; i++) begin
            acc_sum = acc_sum + term[i];
        end
    end

    assign sat_probe = SAT_PROBE_W'(acc_sum);

    // Clamp the wide sum back into the potential range; the low bits of the
    // accumulator are only taken when the value is already in range.
    always_comb begin
        pot_upd = acc_sum[POT_W-1:0];
        case (sat_class(sat_probe, POT_W))
            SAT_MAX:  pot_upd = POT_MAX;
            SAT_ZERO: pot_upd = '0;
            default:  pot_upd = acc_sum[POT_W-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pot_d   = pot_q;
        spike_d = 1'b0;

        if (neuron_rst) begin
            // Takes priority over everything, including a threshold crossing
            // in the same cycle; holding it keeps the counter loaded.
            state_d = ST_REFRACTORY;
            cnt_d   = REFRAC_C;
            pot_d   = '0;
        end else begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (step) begin
                        if (pot_upd >= THRESH_C) begin
                            spike_d = 1'b1;
                            pot_d   = '0;
                            state_d = ST_REFRACTORY;
                            cnt_d   = REFRAC_C;
                        end else begin
                            pot_d = pot_upd;
                        end
                    end
                end
                ST_REFRACTORY: begin
                    pot_d = '0;
                    if (cnt_q == '0) begin
                        // Only reachable with REFRAC=0: no refractory steps
                        // to wait for, so leave on the next edge.
                        state_d = ST_INTEGRATE;
                    end else if (step) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_INTEGRATE;
                        end
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = '0;
                    pot_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_REFRACTORY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INTEGRATE;
            cnt_q   <= '0;
            pot_q   <= '0;
            spike_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pot_q   <= pot_d;
            spike_q <= spike_d;
            busy_q  <= busy_d;
        end
    end

    assign spike_out   = spike_q;
    assign refrac_busy = busy_q;
    assign potential   = pot_q;

endmodule : if_neuron

// File: rtl/if_neuron_layer.sv
// -----------------------------------------------------------------------------
// if_neuron_layer -- NUM_OUTPUTS independent integrate-and-fire neurons sharing
// one set of presynaptic spike lines and one time-step strobe.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous active-low reset
//   step         : time-step strobe, one integration step per cycle it is high
//   spike_in     : NUM_INPUTS presynaptic spikes
//   weights      : neuron j, input i at (j*NUM_INPUTS+i)*WEIGHT_W, signed
//   neuron_rst   : per-neuron reset request from the layer controller
//   spike_out    : per-neuron one-cycle spike, feeds the controller directly
//   refrac_busy  : per-neuron refractory flag
//   potential    : neuron j's membrane potential at j*POT_W
// -----------------------------------------------------------------------------
module if_neuron_layer
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 1,
    parameter int WEIGHT_W    = 8,
    parameter int POT_W       = 16,
    parameter int THRESHOLD   = 100,
    parameter int REFRAC      = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       step,
    input  logic [NUM_INPUTS-1:0]                      spike_in,
    input  logic [NUM_INPUTS*NUM_OUTPUTS*WEIGHT_W-1:0] weights,
    input  logic [NUM_OUTPUTS-1:0]                     neuron_rst,
    output logic [NUM_OUTPUTS-1:0]                     spike_out,
    output logic [NUM_OUTPUTS-1:0]                     refrac_busy,
    output logic [NUM_OUTPUTS*POT_W-1:0]               potential
);

    localparam int ROW_W = NUM_INPUTS * WEIGHT_W;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_neuron
            if_neuron #(
                .NUM_INPUTS (NUM_INPUTS),
                .WEIGHT_W   (WEIGHT_W),
                .POT_W      (POT_W),
                .THRESHOLD  (THRESHOLD),
                .REFRAC     (REFRAC)
            ) u_neuron (
                .clk         (clk),
                .rst         (rst),
                .step        (step),
                .spike_in    (spike_in),
                .weights     (weights[gi*ROW_W +: ROW_W]),
                .neuron_rst  (neuron_rst[gi]),
                .spike_out   (spike_out[gi]),
                .refrac_busy (refrac_busy[gi]),
                .potential   (potential[gi*POT_W +: POT_W])
            );
        end
    endgenerate

endmodule : if_neuron_layer
